// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: state encoding, default
// sizing and the byte width used on every data path.
package uart_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Arbiter state encoding (2-bit, kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_START = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd2;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting one
// past the last granted index, wrapping from NUM_REQ-1 back to 0.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // First requester found after the pointer wins; the pointer itself is checked last
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        grant    = '0;
        any_req  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any_req && req[cand_idx]) begin
                any_req = 1'b1;
                grant   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter handing a single UART transmitter to NUM_REQ byte
// requesters. Optional start-acknowledge watchdog enabled by defining
// UART_TX_ARB_TIMEOUT_EN; without it WAIT_START waits indefinitely and
// Timeout_Err is tied low.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         Req_Valid,
    input  logic [BYTE_W*NUM_REQ-1:0]  Req_Data,
    output logic [NUM_REQ-1:0]         Req_Ready,
    output logic                       TX_Send,
    output logic [BYTE_W-1:0]          TX_Byte,
    input  logic                       TX_Active,
    output logic [$clog2(NUM_REQ)-1:0] Grant_Id,
    output logic                       Busy,
    output logic                       Tx_Done,
    output logic                       Timeout_Err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Reject configurations the arbiter is not built for at elaboration time
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req     (Req_Valid),
        .ptr     (rr_ptr),
        .grant   (pick_idx),
        .any_req (pick_any)
    );

    assign Busy = (state != ST_IDLE);

    // Arbiter FSM: grant in IDLE, wait for the transmitter to start, then to finish
    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state     <= ST_IDLE;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            TX_Send   <= 1'b0;
            Req_Ready <= '0;
            TX_Byte   <= '0;
            Grant_Id  <= '0;
            Tx_Done   <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            Timeout_Err <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            // Strobes are single-cycle: low unless re-asserted below
            TX_Send   <= 1'b0;
            Req_Ready <= '0;
            Tx_Done   <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            Timeout_Err <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    // A busy transmitter (e.g. mid-frame across our reset) blocks any grant
                    if (!TX_Active && pick_any) begin
                        TX_Byte   <= Req_Data[BYTE_W*pick_idx +: BYTE_W];
                        TX_Send   <= 1'b1;
                        Req_Ready <= NUM_REQ'(1) << pick_idx;
                        Grant_Id  <= pick_idx;
                        rr_ptr    <= pick_idx;
                        state     <= ST_WAIT_START;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                ST_WAIT_START: begin
                    if (TX_Active) begin
                        state <= ST_WAIT_DONE;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Byte is dropped; the pointer keeps the failed grant
                        state       <= ST_IDLE;
                        Timeout_Err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (!TX_Active) begin
                        state   <= ST_IDLE;
                        Tx_Done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef UART_TX_ARB_TIMEOUT_EN
    assign Timeout_Err = 1'b0;
`endif

endmodule
